interval_timer: RTL and testbench
=================================

INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 SHALL have parameter PSC_W, default 8: prescaler field width, 1..16.
REQ-002 SHALL have port clk_in, input, 1: single system clock; all state on rising edge.
REQ-003 SHALL have port reset_in, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port bus_slave, wb_bus slave modport, n/a: Wishbone classic register port, 32-bit data, word-addressed by adr[3:2].
REQ-005 SHALL have port irq_out, output, 1: level interrupt, intended for one external_irq_controller irq_lines_in bit.

Function
REQ-006 SHALL decode four word registers by adr[3:2]: 0 CTRL, 1 COMPARE, 2 COUNT, 3 STATUS; sel ignored, full-word access only.
REQ-007 SHALL define CTRL bits: [0] EN, [1] ONESHOT, [2] AUTORELOAD, [3] IRQ_EN, [PSC_W+7:8] PSC; other bits read 0.
REQ-008 SHALL assert ack exactly one cycle after cyc&stb is sampled high, for one cycle; ack SHALL NOT be asserted in two consecutive cycles (new request needs stb sampled while ack low).
REQ-009 SHALL register read data, valid in the ack cycle, and hold it at zero when ack is low.
REQ-010 SHALL commit writes on the ack cycle; reads have no side effects.
REQ-011 SHALL generate tick once every PSC+1 clocks while EN=1; prescaler counter SHALL hold at 0 while EN=0.
REQ-012 SHALL, on tick: if COUNT==COMPARE then set STATUS.MATCH, COUNT <= AUTORELOAD ? 0 : COUNT+1, and if ONESHOT clear EN; else COUNT <= COUNT+1.
REQ-013 SHALL wrap COUNT from 32'hFFFF_FFFF to 0 without side effects.
REQ-014 SHALL, on COUNT write, load the written value, discard any same-cycle tick, and reset the prescaler counter to 0.
REQ-015 SHALL treat STATUS[0] (MATCH) as write-1-to-clear; a same-cycle match set SHALL win over a clear.
REQ-016 SHALL drive irq_out as a register of MATCH & IRQ_EN (one-cycle latency from MATCH).
REQ-017 SHALL, on a CTRL write that sets EN from 0, start counting from current COUNT with prescaler at 0.

Reset
REQ-018 SHALL, while reset_in high, force CTRL, COMPARE, COUNT, MATCH, prescaler, ack, read data and irq_out to 0, regardless of clock.
REQ-019 SHALL abandon any in-flight bus cycle on reset; no ack is issued for it after release.

Configuration
REQ-020 SHALL, with TIMER_PRESCALER_EN defined, implement PSC and the prescaler as in REQ-011.
REQ-021 SHALL, without TIMER_PRESCALER_EN, tick every clock while EN=1, ignore PSC writes, read PSC as 0, and contain no prescaler logic.

Structure
REQ-022 SHALL take register offsets, CTRL bit indices and a packed ctrl_t struct from shared package timer_pkg.
REQ-023 SHALL place the prescaler in sub-module timer_prescaler (inputs en, psc, restart; output tick).

Verification
REQ-024 SHALL test: PSC=0, COMPARE=4, AUTORELOAD=1, EN=1 -> MATCH set on 5th tick; COUNT reads 0,1,2,3,4,0 pattern; irq_out high one cycle after MATCH when IRQ_EN=1.
REQ-025 SHALL test: PSC=3, COMPARE=2 -> ticks every 4 clocks; MATCH 12 clocks after enable (prescaler build only).
REQ-026 SHALL test: ONESHOT=1, COMPARE=1 -> EN reads 0 after match; COUNT stays 2 for 20 further clocks.
REQ-027 SHALL test: COUNT written 32'hFFFF_FFFF, COMPARE=5, PSC=0 -> next tick COUNT=0, no MATCH until COUNT==5.
REQ-028 SHALL test: STATUS write 1 in same cycle as match tick -> MATCH remains 1; a later write 1 clears MATCH and irq_out falls next cycle.
REQ-029 SHALL test: reset_in asserted mid-count with cyc&stb high -> all outputs 0 immediately, no ack after release.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared register map, CTRL bit layout and the CTRL word decoder for interval_timer.
package timer_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_COMPARE = 2'd1;
    localparam logic [1:0] REG_COUNT   = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int CTRL_EN_BIT         = 0;
    localparam int CTRL_ONESHOT_BIT    = 1;
    localparam int CTRL_AUTORELOAD_BIT = 2;
    localparam int CTRL_IRQ_EN_BIT     = 3;
    localparam int CTRL_PSC_LSB        = 8;
    localparam int PSC_MAX_W           = 16;
    localparam int STATUS_MATCH_BIT    = 0;

    // Bit-for-bit image of the CTRL register as seen on the bus
    typedef struct packed {
        logic [7:0]  rsvd_hi;
        logic [15:0] psc;
        logic [3:0]  rsvd_lo;
        logic        irq_en;
        logic        autoreload;
        logic        oneshot;
        logic        en;
    } ctrl_t;

    function automatic ctrl_t ctrl_from_word(input logic [31:0] word, input logic [15:0] psc_mask);
        ctrl_t c;
        c            = ctrl_t'(32'd0);
        c.en         = word[CTRL_EN_BIT];
        c.oneshot    = word[CTRL_ONESHOT_BIT];
        c.autoreload = word[CTRL_AUTORELOAD_BIT];
        c.irq_en     = word[CTRL_IRQ_EN_BIT];
        c.psc        = word[CTRL_PSC_LSB +: PSC_MAX_W] & psc_mask;
        return c;
    endfunction

endpackage

// File: rtl/wb_bus.sv
// Wishbone classic bus bundle, 32-bit data, byte address with word registers.
interface wb_bus;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;

    modport master (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack);
    modport slave  (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack);
endinterface

// File: rtl/timer_prescaler.sv
// Clock divider for interval_timer: one tick every psc+1 clocks while enabled.
module timer_prescaler #(
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PSC_W-1:0] psc,
    input  logic             restart,
    output logic             tick
);

    logic [PSC_W-1:0] cnt_r;
    logic             wrap_s;

    // >= keeps the divider bounded if PSC is lowered while running
    assign wrap_s = (cnt_r >= psc);
    assign tick   = en & ~restart & wrap_s;

    // Divider counter, parked at zero while disabled or restarted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {PSC_W{1'b0}};
        end else if (~en | restart | wrap_s) begin
            cnt_r <= {PSC_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + PSC_W'(1'b1);
        end
    end

endmodule

// File: rtl/interval_timer.sv
// interval_timer: Wishbone-mapped 32-bit interval timer with compare match interrupt.
// Build option: define TIMER_PRESCALER_EN to include the PSC clock prescaler.
module interval_timer
    import timer_pkg::*;
#(
    parameter int PSC_W = 8
) (
    input  logic clk_in,
    input  logic reset_in,
    wb_bus.slave bus_slave,
    output logic irq_out
);

`ifdef TIMER_PRESCALER_EN
    localparam bit PSC_PRESENT = 1'b1;
`else
    localparam bit PSC_PRESENT = 1'b0;
`endif
    localparam logic [15:0] PSC_MASK = PSC_PRESENT ? 16'((32'd1 << PSC_W) - 32'd1) : 16'd0;

    ctrl_t       ctrl_r;
    ctrl_t       ctrl_next_s;
    logic [31:0] compare_r;
    logic [31:0] count_r;
    logic [31:0] count_next_s;
    logic        match_r;
    logic        match_next_s;
    logic        ack_r;
    logic        irq_r;
    logic [31:0] rdata_r;
    logic [31:0] rd_word_s;
    logic [1:0]  reg_sel_s;
    logic        req_s;
    logic        wr_s;
    logic        ctrl_wr_s;
    logic        compare_wr_s;
    logic        count_wr_s;
    logic        status_wr_s;
    logic        tick_s;
    logic        hit_s;
    logic        unused_bus_s;

    assign reg_sel_s    = bus_slave.adr[3:2];
    assign req_s        = bus_slave.cyc & bus_slave.stb & ~ack_r;
    assign wr_s         = ack_r & bus_slave.cyc & bus_slave.stb & bus_slave.we;
    assign unused_bus_s = ^{bus_slave.adr[31:4], bus_slave.adr[1:0], bus_slave.sel};

    assign bus_slave.ack   = ack_r;
    assign bus_slave.dat_r = rdata_r;
    assign irq_out         = irq_r;

`ifdef TIMER_PRESCALER_EN
    timer_prescaler #(
        .PSC_W (PSC_W)
    ) u_prescaler (
        .clk     (clk_in),
        .rst     (reset_in),
        .en      (ctrl_r.en),
        .psc     (ctrl_r.psc[PSC_W-1:0]),
        .restart (count_wr_s),
        .tick    (tick_s)
    );
`else
    assign tick_s = ctrl_r.en;
`endif

    // Write strobes, valid only in the ack cycle of a write
    always_comb begin
        ctrl_wr_s    = 1'b0;
        compare_wr_s = 1'b0;
        count_wr_s   = 1'b0;
        status_wr_s  = 1'b0;
        if (wr_s) begin
            case (reg_sel_s)
                REG_CTRL:    ctrl_wr_s    = 1'b1;
                REG_COMPARE: compare_wr_s = 1'b1;
                REG_COUNT:   count_wr_s   = 1'b1;
                REG_STATUS:  status_wr_s  = 1'b1;
                default:     ctrl_wr_s    = 1'b0;
            endcase
        end else begin
            ctrl_wr_s = 1'b0;
        end
    end

    // Read multiplexer
    always_comb begin
        rd_word_s = 32'd0;
        case (reg_sel_s)
            REG_CTRL:    rd_word_s = ctrl_r;
            REG_COMPARE: rd_word_s = compare_r;
            REG_COUNT:   rd_word_s = count_r;
            REG_STATUS:  rd_word_s = {31'd0, match_r};
            default:     rd_word_s = 32'd0;
        endcase
    end

    // A COUNT write swallows any tick in the same cycle, so it also blocks a match
    assign hit_s = tick_s & ~count_wr_s & (count_r == compare_r);

    // Timer next-state: counter, CTRL (one-shot disable) and sticky MATCH
    always_comb begin
        count_next_s = count_r;
        ctrl_next_s  = ctrl_r;
        match_next_s = match_r;

        if (count_wr_s) begin
            count_next_s = bus_slave.dat_w;
        end else if (hit_s) begin
            count_next_s = ctrl_r.autoreload ? 32'd0 : count_r + 32'd1;
        end else if (tick_s) begin
            count_next_s = count_r + 32'd1;
        end else begin
            count_next_s = count_r;
        end

        if (ctrl_wr_s) begin
            ctrl_next_s = ctrl_from_word(bus_slave.dat_w, PSC_MASK);
        end else if (hit_s & ctrl_r.oneshot) begin
            ctrl_next_s.en = 1'b0;
        end else begin
            ctrl_next_s = ctrl_r;
        end

        if (hit_s) begin
            match_next_s = 1'b1;
        end else if (status_wr_s & bus_slave.dat_w[STATUS_MATCH_BIT]) begin
            match_next_s = 1'b0;
        end else begin
            match_next_s = match_r;
        end
    end

    // Bus handshake: single-cycle ack and registered read data, zero outside ack
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            ack_r   <= 1'b0;
            rdata_r <= 32'd0;
        end else if (req_s) begin
            ack_r   <= 1'b1;
            rdata_r <= rd_word_s;
        end else begin
            ack_r   <= 1'b0;
            rdata_r <= 32'd0;
        end
    end

    // Timer state registers
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            ctrl_r    <= ctrl_t'(32'd0);
            compare_r <= 32'd0;
            count_r   <= 32'd0;
            match_r   <= 1'b0;
        end else begin
            ctrl_r    <= ctrl_next_s;
            compare_r <= compare_wr_s ? bus_slave.dat_w : compare_r;
            count_r   <= count_next_s;
            match_r   <= match_next_s;
        end
    end

    // Interrupt line follows MATCH gated by IRQ_EN, one cycle later
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= match_r & ctrl_r.irq_en;
        end
    end

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer: bus reads go through an expected-value scoreboard,
// interrupt timing is checked cycle by cycle against hand-derived tick schedules.
module tb_interval_timer;

    logic clk_in = 1'b0;
    logic reset_in;
    logic irq_out;

    wb_bus bus ();

    interval_timer #(
        .PSC_W (8)
    ) dut (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .bus_slave (bus),
        .irq_out   (irq_out)
    );

    always #5 clk_in = ~clk_in;

    localparam logic [31:0] A_CTRL    = 32'h0000_0000;
    localparam logic [31:0] A_COMPARE = 32'h0000_0004;
    localparam logic [31:0] A_COUNT   = 32'h0000_0008;
    localparam logic [31:0] A_STATUS  = 32'h0000_000C;
    localparam logic [31:0] C_EN      = 32'h0000_0001;
    localparam logic [31:0] C_ONESHOT = 32'h0000_0002;
    localparam logic [31:0] C_AUTO    = 32'h0000_0004;
    localparam logic [31:0] C_IRQEN   = 32'h0000_0008;
    localparam logic [31:0] C_PSC3    = 32'h0000_0300;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the ack cycle has closed.
    task automatic bus_cycle(input logic wr, input logic [31:0] adr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic got_ack);
        int waited;
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = wr;
        bus.adr   = adr;
        bus.dat_w = wdata;
        bus.sel   = 4'hF;
        got_ack   = 1'b0;
        rdata     = 32'd0;
        waited    = 0;
        while (!got_ack && waited < 8) begin
            @(negedge clk_in);
            waited++;
            if (bus.ack === 1'b1) begin
                got_ack = 1'b1;
                rdata   = bus.dat_r;
            end
        end
        check("ack_seen", 32'(got_ack), 32'd1);
        @(negedge clk_in);
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
        check("ack_single_cycle", 32'(bus.ack), 32'd0);
        check("rdata_zero_idle", bus.dat_r, 32'd0);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] data);
        logic [31:0] rd;
        logic        ok;
        bus_cycle(1'b1, adr, data, rd, ok);
    endtask

    task automatic read_expect(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        ok;
        string       t;
        logic [31:0] e;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus_cycle(1'b0, adr, 32'd0, rd, ok);
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        if (ok) begin
            check(t, rd, e);
        end
    endtask

    task automatic quiesce(input logic [31:0] compare);
        wb_write(A_CTRL, 32'd0);
        wb_write(A_COUNT, 32'd0);
        wb_write(A_STATUS, 32'd1);
        wb_write(A_COMPARE, compare);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_in  = 1'b1;
        bus.cyc   = 1'b0;
        bus.stb   = 1'b0;
        bus.we    = 1'b0;
        bus.adr   = 32'd0;
        bus.sel   = 4'h0;
        bus.dat_w = 32'd0;
        repeat (3) @(negedge clk_in);
        check("rst_irq", 32'(irq_out), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_rdata", bus.dat_r, 32'd0);
        reset_in = 1'b0;
        @(negedge clk_in);
        read_expect("rst_ctrl", A_CTRL, 32'd0);
        read_expect("rst_compare", A_COMPARE, 32'd0);
        read_expect("rst_count", A_COUNT, 32'd0);
        read_expect("rst_status", A_STATUS, 32'd0);

        // Free-running, COMPARE=4: match on the 5th tick, irq one clock later
        wb_write(A_COMPARE, 32'd4);
        wb_write(A_CTRL, C_EN | C_AUTO | C_IRQEN);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_in);
            check($sformatf("irq_5th_tick_k%0d", k), 32'(irq_out), 32'(k == 6));
        end
        read_expect("match_after_5", A_STATUS, 32'd1);

        // Reads spaced 6 clocks apart walk the 0..4 autoreload sequence one step each
        quiesce(32'd4);
        read_expect("status_cleared", A_STATUS, 32'd0);
        wb_write(A_CTRL, C_EN | C_AUTO);
        for (int i = 0; i < 6; i++) begin
            read_expect($sformatf("count_seq_%0d", i), A_COUNT, 32'(i % 5));
            if (i < 5) repeat (4) @(negedge clk_in);
        end

        // Prescaler: PSC=3, COMPARE=2
        quiesce(32'd2);
        wb_write(A_CTRL, C_EN | C_IRQEN | C_PSC3);
`ifdef TIMER_PRESCALER_EN
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk_in);
            check($sformatf("psc_irq_k%0d", k), 32'(irq_out), 32'(k == 13));
        end
        read_expect("psc_ctrl", A_CTRL, C_EN | C_IRQEN | C_PSC3);
`else
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_in);
            check($sformatf("nopsc_irq_k%0d", k), 32'(irq_out), 32'(k == 4));
        end
        read_expect("nopsc_ctrl", A_CTRL, C_EN | C_IRQEN);
`endif

        // One-shot: EN drops at the match and COUNT parks at 2
        quiesce(32'd1);
        wb_write(A_CTRL, C_EN | C_ONESHOT);
        repeat (4) @(negedge clk_in);
        read_expect("oneshot_ctrl", A_CTRL, C_ONESHOT);
        read_expect("oneshot_count", A_COUNT, 32'd2);
        repeat (20) @(negedge clk_in);
        read_expect("oneshot_count_held", A_COUNT, 32'd2);
        read_expect("oneshot_status", A_STATUS, 32'd1);

        // Wrap from all-ones to zero without a match
        wb_write(A_CTRL, 32'd0);
        wb_write(A_STATUS, 32'd1);
        wb_write(A_COMPARE, 32'd5);
        wb_write(A_COUNT, 32'hFFFF_FFFF);
        read_expect("wrap_loaded", A_COUNT, 32'hFFFF_FFFF);
        wb_write(A_CTRL, C_EN | C_IRQEN);
        @(negedge clk_in);
        read_expect("wrap_to_zero", A_COUNT, 32'd0);
        read_expect("wrap_no_match", A_STATUS, 32'd0);
        for (int k = 6; k <= 8; k++) begin
            @(negedge clk_in);
            check($sformatf("wrap_irq_k%0d", k), 32'(irq_out), 32'(k == 8));
        end

        // Clear racing a match loses; a later clear drops irq one clock after
        quiesce(32'd3);
        wb_write(A_CTRL, C_EN | C_IRQEN);
        repeat (2) @(negedge clk_in);
        wb_write(A_STATUS, 32'd1);
        @(negedge clk_in);
        check("race_irq", 32'(irq_out), 32'd1);
        read_expect("race_match_kept", A_STATUS, 32'd1);
        wb_write(A_STATUS, 32'd1);
        check("clear_irq_still_high", 32'(irq_out), 32'd1);
        @(negedge clk_in);
        check("clear_irq_fall", 32'(irq_out), 32'd0);
        read_expect("clear_status", A_STATUS, 32'd0);

        // Reset in the middle of an acked bus cycle with counting active
        quiesce(32'd1);
        wb_write(A_CTRL, C_EN | C_AUTO | C_IRQEN);
        repeat (6) @(negedge clk_in);
        check("pre_rst_irq", 32'(irq_out), 32'd1);
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
        bus.we  = 1'b0;
        bus.adr = A_CTRL;
        @(posedge clk_in);
        #2;
        check("pre_rst_ack", 32'(bus.ack), 32'd1);
        check("pre_rst_rdata", bus.dat_r, C_EN | C_AUTO | C_IRQEN);
        reset_in = 1'b1;
        #1;
        check("rst_async_ack", 32'(bus.ack), 32'd0);
        check("rst_async_rdata", bus.dat_r, 32'd0);
        check("rst_async_irq", 32'(irq_out), 32'd0);
        @(negedge clk_in);
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        @(negedge clk_in);
        reset_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_in);
            check($sformatf("no_ack_after_rst_%0d", k), 32'(bus.ack), 32'd0);
        end
        read_expect("post_rst_ctrl", A_CTRL, 32'd0);
        read_expect("post_rst_compare", A_COMPARE, 32'd0);
        read_expect("post_rst_count", A_COUNT, 32'd0);
        read_expect("post_rst_status", A_STATUS, 32'd0);
        check("post_rst_irq", 32'(irq_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
